// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-bus LCD driver.
// FSM state and byte-phase codes, ILI9341 opcodes, init-ROM wait selector
// and the ROM entry layout.
package lcd_pkg;

    localparam int unsigned CNT_W  = 21;
    localparam int unsigned ROM_AW = 3;
    localparam int unsigned IDX_W  = 4;

    localparam logic [2:0] ST_RST_LOW  = 3'd0;
    localparam logic [2:0] ST_RST_WAIT = 3'd1;
    localparam logic [2:0] ST_INIT     = 3'd2;
    localparam logic [2:0] ST_IDLE     = 3'd3;
    localparam logic [2:0] ST_CURSOR   = 3'd4;
    localparam logic [2:0] ST_PIX_HI   = 3'd5;
    localparam logic [2:0] ST_PIX_LO   = 3'd6;

    // Byte phases: A drives WRX low with data, B raises WRX, WAIT holds off.
    localparam logic [1:0] PH_A    = 2'd0;
    localparam logic [1:0] PH_B    = 2'd1;
    localparam logic [1:0] PH_WAIT = 2'd2;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam logic [7:0] COLMOD_RGB565     = 8'h55;
    localparam logic [7:0] MADCTL_LANDSCAPE  = 8'h28;

    typedef enum logic [1:0] {
        WAIT_NONE  = 2'd0,
        WAIT_SHORT = 2'd1,
        WAIT_LONG  = 2'd2
    } wait_sel_e;

    typedef struct packed {
        logic      is_cmd;
        logic [7:0] data;
        wait_sel_e wait_sel;
        logic      last;
    } rom_entry_t;

endpackage

// File: rtl/lcd_init_rom.sv
// Panel init sequence ROM: index -> {is_cmd, byte, wait_sel, last}.
// Ports: i_idx (entry index), o_entry (entry; index 7 is the end marker).
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [ROM_AW-1:0] i_idx,
    output rom_entry_t        o_entry
);

    always_comb begin
        o_entry = '{1'b0, 8'h00, WAIT_NONE, 1'b1};
        case (i_idx)
            3'd0:    o_entry = '{1'b1, CMD_SWRESET,      WAIT_SHORT, 1'b0};
            3'd1:    o_entry = '{1'b1, CMD_SLPOUT,       WAIT_LONG,  1'b0};
            3'd2:    o_entry = '{1'b1, CMD_COLMOD,       WAIT_NONE,  1'b0};
            3'd3:    o_entry = '{1'b0, COLMOD_RGB565,    WAIT_NONE,  1'b0};
            3'd4:    o_entry = '{1'b1, CMD_MADCTL,       WAIT_NONE,  1'b0};
            3'd5:    o_entry = '{1'b0, MADCTL_LANDSCAPE, WAIT_NONE,  1'b0};
            3'd6:    o_entry = '{1'b1, CMD_DISPON,       WAIT_NONE,  1'b0};
            default: o_entry = '{1'b0, 8'h00,            WAIT_NONE,  1'b1};
        endcase
    end

endmodule

// File: rtl/lcd_8080_driver.sv
// RGB565 pixel stream to ILI9341-class 8080 8-bit bus, with panel power-up.
// Inputs : clk, reset (sync, active high), pix_data[15:0], pix_clk,
//          reset_cursor.
// Outputs: busy, nreset, cmd_data (1=data), write_edge (WRX), dout[7:0].
// Define LCD_FAST_SIM_EN to shrink the reset-low, short and long waits to
// 16 cycles each; byte sequences are unchanged.
module lcd_8080_driver
    import lcd_pkg::*;
#(
    parameter int unsigned WIDTH             = 320,
    parameter int unsigned HEIGHT            = 240,
    parameter int unsigned RST_LOW_CYCLES    = 160,
    parameter int unsigned LONG_WAIT_CYCLES  = 1_920_000,
    parameter int unsigned SHORT_WAIT_CYCLES = 80_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pix_data,
    input  logic        pix_clk,
    input  logic        reset_cursor,
    output logic        busy,
    output logic        nreset,
    output logic        cmd_data,
    output logic        write_edge,
    output logic [7:0]  dout
);

`ifdef LCD_FAST_SIM_EN
    localparam logic [CNT_W-1:0] RST_LOW_N = CNT_W'(16);
    localparam logic [CNT_W-1:0] LONG_N    = CNT_W'(16);
    localparam logic [CNT_W-1:0] SHORT_N   = CNT_W'(16);
`else
    localparam logic [CNT_W-1:0] RST_LOW_N = CNT_W'(RST_LOW_CYCLES);
    localparam logic [CNT_W-1:0] LONG_N    = CNT_W'(LONG_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] SHORT_N   = CNT_W'(SHORT_WAIT_CYCLES);
`endif

    localparam logic [15:0]      COL_END     = 16'(WIDTH - 1);
    localparam logic [15:0]      ROW_END     = 16'(HEIGHT - 1);
    localparam logic [IDX_W-1:0] CURSOR_LAST = IDX_W'(10);

    // Address-window sequence: returns {is_cmd, byte}.
    function automatic logic [8:0] cursor_byte(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:       cursor_byte = {1'b1, CMD_CASET};
            4'd1, 4'd2: cursor_byte = {1'b0, 8'h00};
            4'd3:       cursor_byte = {1'b0, COL_END[15:8]};
            4'd4:       cursor_byte = {1'b0, COL_END[7:0]};
            4'd5:       cursor_byte = {1'b1, CMD_PASET};
            4'd6, 4'd7: cursor_byte = {1'b0, 8'h00};
            4'd8:       cursor_byte = {1'b0, ROW_END[15:8]};
            4'd9:       cursor_byte = {1'b0, ROW_END[7:0]};
            default:    cursor_byte = {1'b1, CMD_RAMWR};
        endcase
    endfunction

    logic [2:0]       r_state,      w_state;
    logic [1:0]       r_phase,      w_phase;
    logic [IDX_W-1:0] r_idx,        w_idx;
    logic [CNT_W-1:0] r_wait_cnt,   w_wait_cnt;
    logic [15:0]      r_pix,        w_pix;
    logic             r_pix_pend,   w_pix_pend;
    logic             r_busy,       w_busy;
    logic             r_nreset,     w_nreset;
    logic             r_cmd_data,   w_cmd_data;
    logic             r_write_edge, w_write_edge;
    logic [7:0]       r_dout,       w_dout;

    logic [ROM_AW-1:0] w_rom_nxt_idx;
    rom_entry_t        w_rom_cur;
    rom_entry_t        w_rom_nxt;
    logic [8:0]        w_cur_first;
    logic [8:0]        w_cur_nxt;
    logic [CNT_W-1:0]  w_wait_len;
    logic              w_wait_done;
    logic              w_init_adv;
    logic              w_cursor_go;
    logic              w_unused_ok;

    // Current entry and its successor, so the next byte can be loaded on phase B.
    assign w_rom_nxt_idx = r_idx[ROM_AW-1:0] + ROM_AW'(1);

    lcd_init_rom u_rom_cur (.i_idx(r_idx[ROM_AW-1:0]), .o_entry(w_rom_cur));
    lcd_init_rom u_rom_nxt (.i_idx(w_rom_nxt_idx),     .o_entry(w_rom_nxt));

    assign w_cur_first = cursor_byte(IDX_W'(0));
    assign w_cur_nxt   = cursor_byte(r_idx + IDX_W'(1));
    assign w_unused_ok = ^{w_rom_cur.last, w_rom_nxt.wait_sel};

    // Wait length for whichever state is counting.
    always_comb begin
        case (r_state)
            ST_RST_LOW:  w_wait_len = RST_LOW_N;
            ST_RST_WAIT: w_wait_len = LONG_N;
            default:     w_wait_len = (w_rom_cur.wait_sel == WAIT_LONG) ? LONG_N : SHORT_N;
        endcase
    end

    assign w_wait_done = (r_wait_cnt == w_wait_len - CNT_W'(1));

    // Next-state and next-output logic; outputs are loaded one cycle ahead.
    always_comb begin
        w_state      = r_state;
        w_phase      = r_phase;
        w_idx        = r_idx;
        w_wait_cnt   = r_wait_cnt;
        w_pix        = r_pix;
        w_pix_pend   = r_pix_pend;
        w_nreset     = r_nreset;
        w_cmd_data   = r_cmd_data;
        w_write_edge = r_write_edge;
        w_dout       = r_dout;
        w_init_adv   = 1'b0;
        w_cursor_go  = 1'b0;

        case (r_state)
            ST_RST_LOW: begin
                if (w_wait_done) begin
                    w_wait_cnt = '0;
                    w_nreset   = 1'b1;
                    w_state    = ST_RST_WAIT;
                end else begin
                    w_wait_cnt = r_wait_cnt + CNT_W'(1);
                end
            end
            ST_RST_WAIT: begin
                if (w_wait_done) begin
                    w_wait_cnt   = '0;
                    w_state      = ST_INIT;
                    w_idx        = '0;
                    w_phase      = PH_A;
                    w_write_edge = 1'b0;
                    w_cmd_data   = ~w_rom_cur.is_cmd;
                    w_dout       = w_rom_cur.data;
                end else begin
                    w_wait_cnt = r_wait_cnt + CNT_W'(1);
                end
            end
            ST_INIT: begin
                case (r_phase)
                    PH_A: begin
                        w_phase      = PH_B;
                        w_write_edge = 1'b1;
                    end
                    PH_B: begin
                        if (w_rom_cur.wait_sel != WAIT_NONE) w_phase = PH_WAIT;
                        else                                  w_init_adv = 1'b1;
                    end
                    default: begin
                        if (w_wait_done) begin
                            w_wait_cnt = '0;
                            w_init_adv = 1'b1;
                        end else begin
                            w_wait_cnt = r_wait_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
            ST_IDLE: begin
                // Cursor wins a tie; the pixel is parked and sent after it.
                if (reset_cursor) begin
                    w_cursor_go = 1'b1;
                    w_pix_pend  = pix_clk;
                    if (pix_clk) w_pix = pix_data;
                end else if (pix_clk) begin
                    w_pix        = pix_data;
                    w_state      = ST_PIX_HI;
                    w_phase      = PH_A;
                    w_write_edge = 1'b0;
                    w_cmd_data   = 1'b1;
                    w_dout       = pix_data[15:8];
                end
            end
            ST_CURSOR: begin
                if (r_phase == PH_A) begin
                    w_phase      = PH_B;
                    w_write_edge = 1'b1;
                end else if (r_idx == CURSOR_LAST) begin
                    w_phase = PH_A;
                    if (r_pix_pend) begin
                        w_pix_pend   = 1'b0;
                        w_state      = ST_PIX_HI;
                        w_write_edge = 1'b0;
                        w_cmd_data   = 1'b1;
                        w_dout       = r_pix[15:8];
                    end else begin
                        w_state = ST_IDLE;
                    end
                end else begin
                    w_idx        = r_idx + IDX_W'(1);
                    w_phase      = PH_A;
                    w_write_edge = 1'b0;
                    w_cmd_data   = ~w_cur_nxt[8];
                    w_dout       = w_cur_nxt[7:0];
                end
            end
            ST_PIX_HI: begin
                if (r_phase == PH_A) begin
                    w_phase      = PH_B;
                    w_write_edge = 1'b1;
                end else begin
                    w_state      = ST_PIX_LO;
                    w_phase      = PH_A;
                    w_write_edge = 1'b0;
                    w_dout       = r_pix[7:0];
                end
            end
            ST_PIX_LO: begin
                if (r_phase == PH_A) begin
                    w_phase      = PH_B;
                    w_write_edge = 1'b1;
                end else begin
                    w_state = ST_IDLE;
                    w_phase = PH_A;
                end
            end
            default: w_state = ST_RST_LOW;
        endcase

        // Step to the next init entry, or hand over to the cursor sequence.
        if (w_init_adv) begin
            w_phase      = PH_A;
            w_write_edge = 1'b0;
            if (w_rom_nxt.last) begin
                w_cursor_go = 1'b1;
            end else begin
                w_idx      = {1'b0, w_rom_nxt_idx};
                w_cmd_data = ~w_rom_nxt.is_cmd;
                w_dout     = w_rom_nxt.data;
            end
        end

        if (w_cursor_go) begin
            w_state      = ST_CURSOR;
            w_idx        = '0;
            w_phase      = PH_A;
            w_write_edge = 1'b0;
            w_cmd_data   = ~w_cur_first[8];
            w_dout       = w_cur_first[7:0];
        end

        w_busy = (w_state != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RST_LOW;
            r_phase      <= PH_A;
            r_idx        <= '0;
            r_wait_cnt   <= '0;
            r_pix        <= '0;
            r_pix_pend   <= 1'b0;
            r_busy       <= 1'b1;
            r_nreset     <= 1'b0;
            r_cmd_data   <= 1'b0;
            r_write_edge <= 1'b1;
            r_dout       <= '0;
        end else begin
            r_state      <= w_state;
            r_phase      <= w_phase;
            r_idx        <= w_idx;
            r_wait_cnt   <= w_wait_cnt;
            r_pix        <= w_pix;
            r_pix_pend   <= w_pix_pend;
            r_busy       <= w_busy;
            r_nreset     <= w_nreset;
            r_cmd_data   <= w_cmd_data;
            r_write_edge <= w_write_edge;
            r_dout       <= w_dout;
        end
    end

    assign busy       = r_busy;
    assign nreset     = r_nreset;
    assign cmd_data   = r_cmd_data;
    assign write_edge = r_write_edge;
    assign dout       = r_dout;

endmodule

// File: tb/tb_lcd_8080_driver.sv
// Directed bench for lcd_8080_driver: power-up sequence, pixel timing,
// dropped strobes, cursor/pixel collision and mid-sequence reset.
module tb_lcd_8080_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_clk = 1'b0;
    logic        reset_cursor = 1'b0;
    logic        busy;
    logic        nreset;
    logic        cmd_data;
    logic        write_edge;
    logic [7:0]  dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lcd_8080_driver #(
        .WIDTH             (320),
        .HEIGHT            (240),
        .RST_LOW_CYCLES    (16),
        .LONG_WAIT_CYCLES  (16),
        .SHORT_WAIT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_data     (pix_data),
        .pix_clk      (pix_clk),
        .reset_cursor (reset_cursor),
        .busy         (busy),
        .nreset       (nreset),
        .cmd_data     (cmd_data),
        .write_edge   (write_edge),
        .dout         (dout)
    );

    // Bytes latched by the panel: {cmd_data, dout} at each WRX rising edge.
    logic [8:0] bus_q[$];
    logic       prev_we = 1'b1;

    always @(negedge clk) begin
        if (write_edge && !prev_we) bus_q.push_back({cmd_data, dout});
        prev_we = write_edge;
    end

    // Power-up bytes: init ROM then cursor window for 320x240.
    logic [8:0] exp_pwr [0:17] = '{
        9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h128, 9'h029,
        9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
        9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF,
        9'h02C
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < bus_q.size()) return 32'(bus_q[i]);
        return 32'hDEAD;
    endfunction

    // Release reset and measure nreset-low time and power-up length in edges.
    task automatic release_and_count(output int n_low, output int n_total);
        int n;
        bus_q.delete();
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (nreset == 1'b0 && n < 1000);
        n_low = n;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        n_total = n;
    endtask

    task automatic check_pwr_seq(input string tag);
        check({tag, "_len"}, 32'(bus_q.size()), 32'd18);
        for (int i = 0; i < 18; i++)
            check($sformatf("%s_b%0d", tag, i), q_at(i), 32'(exp_pwr[i]));
    endtask

    task automatic check_pwr_len(input string tag, input int n_total);
        int exp_total;
        int diff;
        exp_total = 16 + 16 + 14 + 16 + 16 + 22 + 4;
        diff = (n_total > exp_total) ? n_total - exp_total : exp_total - n_total;
        if (diff > 8) $display("  %s: power-up took %0d edges, nominal %0d", tag, n_total, exp_total);
        check(tag, 32'(diff <= 8), 32'd1);
    endtask

    int n_low;
    int n_total;
    int n_busy;

    initial begin
        // Reset values.
        reset = 1'b1;
        repeat (3) tick();
        check("rst_nreset",   32'(nreset),     32'd0);
        check("rst_cmd_data", 32'(cmd_data),   32'd0);
        check("rst_we",       32'(write_edge), 32'd1);
        check("rst_dout",     32'(dout),       32'd0);
        check("rst_busy",     32'(busy),       32'd1);

        // Power-up.
        release_and_count(n_low, n_total);
        check("pwr_nreset_low", 32'(n_low), 32'd16);
        check_pwr_len("pwr_len_ok", n_total);
        check("pwr_busy_low", 32'(busy), 32'd0);
        check_pwr_seq("pwr");

        // Single pixel 0xF81F: cycle T is the current cycle.
        tick();
        bus_q.delete();
        pix_data = 16'hF81F;
        pix_clk  = 1'b1;
        tick();                                   // T+1
        pix_clk  = 1'b0;
        check("px_t1_busy", 32'(busy),       32'd1);
        check("px_t1_we",   32'(write_edge), 32'd0);
        check("px_t1_cd",   32'(cmd_data),   32'd1);
        check("px_t1_dout", 32'(dout),       32'hF8);
        tick();                                   // T+2
        check("px_t2_we",   32'(write_edge), 32'd1);
        check("px_t2_dout", 32'(dout),       32'hF8);
        tick();                                   // T+3
        check("px_t3_we",   32'(write_edge), 32'd0);
        check("px_t3_dout", 32'(dout),       32'h1F);
        check("px_t3_cd",   32'(cmd_data),   32'd1);
        tick();                                   // T+4
        check("px_t4_we",   32'(write_edge), 32'd1);
        check("px_t4_busy", 32'(busy),       32'd1);
        tick();                                   // T+5
        check("px_t5_busy", 32'(busy),       32'd0);
        check("px_nbytes",  32'(bus_q.size()), 32'd2);
        check("px_b0",      q_at(0), 32'h1F8);
        check("px_b1",      q_at(1), 32'h11F);

        // Strobe while busy is dropped.
        tick();
        bus_q.delete();
        pix_data = 16'h5AA5;
        pix_clk  = 1'b1;
        tick();                                   // T+1
        pix_clk  = 1'b0;
        tick();                                   // T+2
        pix_data = 16'hABCD;
        pix_clk  = 1'b1;
        tick();                                   // T+3
        pix_clk  = 1'b0;
        pix_data = 16'h0000;
        tick();                                   // T+4
        tick();                                   // T+5
        check("drop_t5_busy", 32'(busy), 32'd0);
        tick();
        check("drop_t6_busy", 32'(busy), 32'd0);
        tick();
        check("drop_nbytes", 32'(bus_q.size()), 32'd2);
        check("drop_b0",     q_at(0), 32'h15A);
        check("drop_b1",     q_at(1), 32'h1A5);

        // Cursor alone: 22 busy cycles, 11 window bytes.
        bus_q.delete();
        reset_cursor = 1'b1;
        tick();
        reset_cursor = 1'b0;
        n_busy = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            tick();
        end
        check("cur_busy_cycles", 32'(n_busy), 32'd22);
        tick();
        check("cur_nbytes", 32'(bus_q.size()), 32'd11);
        for (int i = 0; i < 11; i++)
            check($sformatf("cur_b%0d", i), q_at(i), 32'(exp_pwr[7 + i]));

        // Cursor and pixel together: cursor first, then the pixel.
        bus_q.delete();
        reset_cursor = 1'b1;
        pix_clk      = 1'b1;
        pix_data     = 16'h1234;
        tick();
        reset_cursor = 1'b0;
        pix_clk      = 1'b0;
        pix_data     = 16'h0000;
        n_busy = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            tick();
        end
        check("both_busy_cycles", 32'(n_busy), 32'd26);
        tick();
        check("both_nbytes", 32'(bus_q.size()), 32'd13);
        for (int i = 0; i < 11; i++)
            check($sformatf("both_b%0d", i), q_at(i), 32'(exp_pwr[7 + i]));
        check("both_px_hi", q_at(11), 32'h112);
        check("both_px_lo", q_at(12), 32'h134);

        // Reset during the 0x3A init command restarts the whole power-up.
        reset = 1'b1;
        tick();
        tick();
        release_and_count(n_low, n_total);
        n_busy = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        while (!(write_edge == 1'b0 && cmd_data == 1'b0 && dout == 8'h3A) && n_busy < 1000) begin
            tick();
            n_busy++;
        end
        check("mid_found_3a", 32'(n_busy < 1000), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_nreset", 32'(nreset),     32'd0);
        check("mid_busy",   32'(busy),       32'd1);
        check("mid_we",     32'(write_edge), 32'd1);
        check("mid_dout",   32'(dout),       32'd0);
        tick();
        release_and_count(n_low, n_total);
        check("mid_nreset_low", 32'(n_low), 32'd16);
        check_pwr_len("mid_len_ok", n_total);
        check_pwr_seq("mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
